// File: rtl/data_bus_arbiter.sv
// -----------------------------------------------------------------------------
// data_bus_arbiter
//
// Purpose:
//   Round-robin arbiter for the shared 64-bit data bus. There are four
//   requesters:
//     req[0] datapath control word
//     req[1] GPIO peripheral
//     req[2] debug read port
//     req[3] user instruction injector
//   An owner keeps the bus for as long as it holds its request. When the owner
//   releases the bus, one idle turnaround cycle is inserted before the next
//   owner is granted, so the tri-state drivers never contend.
//
// Optional feature:
//   BUS_ARB_BURST_LIMIT_EN - when defined, a burst counter limits how long an
//   owner can keep the bus. After MAX_BURST grant cycles, the owner is forced
//   off the bus if another requester is waiting. When the macro is not
//   defined, there is no counter and force_release is tied low.
//
// Handshake:
//   A request is a level. A requester asserts req[i] and keeps it high while
//   it needs the bus. grant[i] rises one cycle after the arbiter samples the
//   winning request. The owner keeps the grant until it samples req[i] low
//   (or until a forced release).
//
// Ports:
//   clock         in   system clock; all state changes on the rising edge
//   reset         in   synchronous, active-high reset
//   req[3:0]      in   bus requests
//   grant[3:0]    out  registered grant; one-hot or zero
//   owner[1:0]    out  index of the current or most recent grant holder
//   bus_busy      out  high whenever grant is nonzero
//   turnaround    out  high during the idle cycle between owners
//   force_release out  one-cycle pulse (in the TURN cycle) after a burst cut
//   state_dbg[1:0]out  FSM state: 0 IDLE, 1 GRANT, 2 TURN
// -----------------------------------------------------------------------------
module data_bus_arbiter #(
  parameter int unsigned MAX_BURST = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] owner,
  output logic       bus_busy,
  output logic       turnaround,
  output logic       force_release,
  output logic [1:0] state_dbg
);

  if (MAX_BURST < 2 || MAX_BURST > 255) begin : g_bad_max_burst
    $error("data_bus_arbiter: MAX_BURST must be in 2..255");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] last_q, last_d;

`ifdef BUS_ARB_BURST_LIMIT_EN
  localparam int unsigned CW = $clog2(MAX_BURST + 1);
  // The counter holds the number of grant cycles the current owner has had,
  // including the current cycle. It is cleared on each new grant and counts
  // the first cycle at once, so it reads 1 in the first GRANT cycle.
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fr_q, fr_d;
  logic          others_pending;
`endif

  // Round-robin pick. The search starts at last_q+1 and wraps round to
  // last_q. The loop goes from the lowest priority slot (i=4, which is last_q)
  // up to the highest (i=1). The last match to write therefore has the
  // highest priority.
  logic [1:0] rr_winner;
  logic       rr_any;
  logic [1:0] rr_idx;

  always_comb begin
    rr_winner = last_q;
    rr_any    = 1'b0;
    rr_idx    = 2'd0;
    for (int i = 4; i >= 1; i--) begin
      rr_idx = last_q + 2'(i);
      if (req[rr_idx]) begin
        rr_winner = rr_idx;
        rr_any    = 1'b1;
      end
    end
  end

`ifdef BUS_ARB_BURST_LIMIT_EN
  assign others_pending = |(req & ~grant_q);
`endif

  // Next-state logic and registered outputs.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    last_d  = last_q;
`ifdef BUS_ARB_BURST_LIMIT_EN
    cnt_d   = cnt_q;
    fr_d    = 1'b0;
`endif
    case (state_q)
      IDLE, TURN: begin
        if (rr_any) begin
          state_d = GRANT;
          grant_d = 4'b0001 << rr_winner;
          owner_d = rr_winner;
          last_d  = rr_winner;
`ifdef BUS_ARB_BURST_LIMIT_EN
          cnt_d   = CW'(1);
`endif
        end else begin
          state_d = IDLE;
          grant_d = 4'b0000;
        end
      end
      GRANT: begin
        if (!req[owner_q]) begin
          state_d = TURN;
          grant_d = 4'b0000;
`ifdef BUS_ARB_BURST_LIMIT_EN
        end else if (cnt_q == CW'(MAX_BURST) && others_pending) begin
          state_d = TURN;
          grant_d = 4'b0000;
          fr_d    = 1'b1;
        end else if (cnt_q != CW'(MAX_BURST)) begin
          cnt_d   = cnt_q + CW'(1);
`endif
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= 4'b0000;
      owner_q <= 2'd0;
      last_q  <= 2'd3;  // req[0] has first priority after reset
`ifdef BUS_ARB_BURST_LIMIT_EN
      cnt_q   <= '0;
      fr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
`ifdef BUS_ARB_BURST_LIMIT_EN
      cnt_q   <= cnt_d;
      fr_q    <= fr_d;
`endif
    end
  end

  assign grant      = grant_q;
  assign owner      = owner_q;
  assign bus_busy   = |grant_q;
  assign turnaround = (state_q == TURN);
  assign state_dbg  = state_q;
`ifdef BUS_ARB_BURST_LIMIT_EN
  assign force_release = fr_q;
`else
  assign force_release = 1'b0;
`endif

endmodule

// File: doc/data_bus_arbiter.md
DATA_BUS_ARBITER -- requirements
Module: data_bus_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_BURST, default 8, giving the maximum GRANT cycles before forced release (range 2..255).
REQ-002 Port clock, input, 1: single system clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1: synchronous, active-high reset.
REQ-004 Port req, input, 4: bus requests; bit 0 datapath control word, bit 1 GPIO peripheral, bit 2 debug read port, bit 3 user instruction injector.
REQ-005 Port grant, output, 4: registered one-hot (or zero) ownership of the shared 64-bit data bus.
REQ-006 Port owner, output, 2: index of the current grant holder; holds its last value when grant is zero.
REQ-007 Port bus_busy, output, 1: high whenever grant is nonzero.
REQ-008 Port turnaround, output, 1: high during the idle cycle inserted between owners.
REQ-009 Port force_release, output, 1: one-cycle pulse when a burst is cut by the limit.

Function
REQ-010 The block SHALL implement three states: IDLE, GRANT, TURN.
REQ-011 The block SHALL ensure grant is never multi-hot, so tri-state drivers on the data bus never contend.
REQ-012 IDLE with any req bit set: on that edge the block SHALL enter GRANT, with grant set for the winner; grant-visible latency is 1 cycle from the sampled req.
REQ-013 The winner SHALL be chosen round-robin: search starts at (last_owner+1) mod 4 and wraps to last_owner; last_owner updates on each new grant.
REQ-014 IDLE with req==0: the block SHALL stay in IDLE with grant=0.
REQ-015 GRANT while req[owner]=1 (and no forced release): grant SHALL hold unchanged, regardless of other requests.
REQ-016 GRANT when req[owner]=0 on the sampling edge: the block SHALL enter TURN with grant cleared on that edge.
REQ-017 TURN SHALL last exactly one cycle with grant=0 and turnaround=1.
REQ-018 TURN with any req set: the block SHALL enter GRANT with the round-robin winner; a new owner is therefore granted no earlier than 2 cycles after the previous owner's req is sampled low.
REQ-019 TURN with req==0: the block SHALL enter IDLE.
REQ-020 A requester that drops req and re-asserts it during TURN SHALL only win again if no other requester is pending (round-robin fairness).
REQ-021 Burst counter: cleared on each new grant; incremented each GRANT cycle; saturates at MAX_BURST.

Reset
REQ-022 On reset the block SHALL force state=IDLE, grant=0, owner=0, bus_busy=0, turnaround=0, force_release=0, burst counter=0, and last_owner=3 so that req[0] has first priority.
REQ-023 Reset asserted mid-GRANT or mid-TURN SHALL take effect on the same edge and override all other transitions.
REQ-024 The first grant after reset deassertion SHALL follow REQ-012 with no extra delay.

Configuration
REQ-025 The macro BUS_ARB_BURST_LIMIT_EN SHALL gate burst limiting.
REQ-026 With BUS_ARB_BURST_LIMIT_EN defined: in GRANT, when the burst counter equals MAX_BURST and any other req bit is set, the block SHALL enter TURN, clear grant, and pulse force_release for that one cycle.
REQ-027 With BUS_ARB_BURST_LIMIT_EN defined and no other requester pending, the owner SHALL keep the grant and the counter SHALL stay saturated.
REQ-028 Without BUS_ARB_BURST_LIMIT_EN: the owner holds the bus indefinitely, force_release SHALL be tied 0, and the counter SHALL be omitted.

Verification
REQ-029 Reset, then req=0001 -> grant=0001 one cycle later, owner=0, bus_busy=1.
REQ-030 req=1111 held, each owner dropping after 1 GRANT cycle -> grant sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001.
REQ-031 Owner 1 holds; req[1] drops while req=1001 -> one TURN cycle (turnaround=1), then grant=1000.
REQ-032 BUS_ARB_BURST_LIMIT_EN, MAX_BURST=8, req=0011 held constantly -> owner 0 holds 8 cycles, force_release pulses, TURN, then grant=0010.
REQ-033 Reset pulsed during GRANT with req=0100 -> grant=0000 on that edge; after release, grant=0100 one cycle later.
REQ-034 Every test SHALL run a continuous check that grant is zero or one-hot and that turnaround never coincides with a nonzero grant.
